// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative multiply unit.
// Optional build macro: MULT_EARLY_OUT_EN (early exit from CALC once the multiplier is exhausted).
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = WIDTH;
  localparam int CNT_W = $clog2(ITER);

  // Counter value seen during the final CALC iteration
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_e;

endpackage

// File: rtl/mult_abs.sv
// Conditional two's-complement negate: outputs -in when neg is set, else in.
// Used both for operand magnitudes and for re-applying the sign to the product.
module mult_abs #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);

  assign out_o = neg_i ? (-in_i) : in_i;

endmodule

// File: rtl/mult_sequencer.sv
// Iterative shift-add 32x32 multiplier with HI/LO result registers and
// pipeline stall generation for HI/LO readers and overlapping multiplies.
// Optional build macro: MULT_EARLY_OUT_EN -- leave CALC as soon as the
// shifted multiplier becomes zero (same result, shorter latency).
module mult_sequencer
  import mult_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_read,
  output logic             mult_busy,
  output logic             mult_stall,
  output logic             mult_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic [WIDTH-1:0]     absA, absB;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   accAdd;
  logic [WIDTH-1:0]     mplierShr;
  logic                 calcLast;

  // Operand magnitudes; a signed 0x80000000 maps back onto itself, which is
  // exactly its unsigned magnitude, so no special case is needed.
  mult_abs #(.W(WIDTH)) uAbsA (
    .in_i  (srca),
    .neg_i (mult_sign & srca[WIDTH-1]),
    .out_o (absA)
  );

  mult_abs #(.W(WIDTH)) uAbsB (
    .in_i  (srcb),
    .neg_i (mult_sign & srcb[WIDTH-1]),
    .out_o (absB)
  );

  // Re-apply the product sign over the full 64-bit accumulator
  mult_abs #(.W(2*WIDTH)) uAbsP (
    .in_i  (acc_q),
    .neg_i (neg_q),
    .out_o (product)
  );

  assign accAdd    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplierShr = mplier_q >> 1;

`ifdef MULT_EARLY_OUT_EN
  assign calcLast = (cnt_q == CNT_LAST) || (mplierShr == '0);
`else
  assign calcLast = (cnt_q == CNT_LAST);
`endif

  // State register for the sequencer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> CALC on a request, CALC -> SIGN after the last iteration
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_mult) state_d = CALC;
      CALC:    if (calcLast)   state_d = SIGN;
      SIGN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load, shift-add iterations, and signed result writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_mult) begin
            mcand_q  <= {{WIDTH{1'b0}}, absA};
            mplier_q <= absB;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          end
        end
        CALC: begin
          acc_q    <= accAdd;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplierShr;
          cnt_q    <= cnt_q + 1'b1;
        end
        SIGN: begin
          {hi_q, lo_q} <= product;
          done_q       <= 1'b1;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign mult_busy  = (state_q != IDLE);
  assign mult_stall = mult_busy & (hilo_read | start_mult);
  assign mult_done  = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Iterative 32x32 multiply unit and its sequencer for the pipelined MIPS core. It is started by the `start_mult`/`mult_sign` outputs of the main controller in EX. It runs a shift-add multiply over multiple cycles and writes the 64-bit result into HI/LO. It stalls the pipeline when an `mfhi`/`mflo` or a second multiply arrives while the unit is busy.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- start_mult  input  1  controller request to begin a multiply; sampled only in IDLE.
- mult_sign  input  1  1 = signed (`mult`), 0 = unsigned (`multu`); sampled with start_mult.
- srca  input  WIDTH  multiplicand (rs).
- srcb  input  WIDTH  multiplier (rt).
- hilo_read  input  1  an instruction in EX reads HI or LO.
- mult_busy  output  1  high while state != IDLE.
- mult_stall  output  1  combinational: mult_busy & (hilo_read | start_mult).
- mult_done  output  1  registered one-cycle pulse on the cycle after HI/LO update.
- hi  output  WIDTH  upper product register.
- lo  output  WIDTH  lower product register.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE: when start_mult=1, load the operands and go to CALC.
  - mcand (2*WIDTH) = zero-extended |srca|; mplier (WIDTH) = |srcb|; acc = 0; cnt = 0.
  - neg = mult_sign & (srca[31] ^ srcb[31]).
  - Absolute value is taken only when mult_sign=1; 0x80000000 stays 0x80000000 as unsigned magnitude.
- CALC, every edge:
  - If mplier[0]=1, acc += mcand (mod 2^64).
  - mcand <<= 1; mplier >>= 1; cnt++.
  - Leave CALC for SIGN on the edge where cnt reaches WIDTH-1.
- SIGN, one edge:
  - {hi,lo} = neg ? -acc : acc (64-bit two's complement).
  - Go to IDLE; set mult_done for the following cycle.
- start_mult while busy is ignored. The resulting mult_stall holds the request in EX until IDLE, then it is accepted.
- hilo_read while busy asserts mult_stall. hi/lo hold their previous values until the SIGN edge.
- start_mult and hilo_read in the same IDLE cycle: no stall. The read returns the old HI/LO and the multiply starts.
- Reset, including mid-operation: state=IDLE, hi=lo=0, acc/mcand/mplier/cnt=0, mult_done=0, mult_busy=0. The partial product is discarded.

## Timing
- Start sampled at edge E0.
- CALC occupies edges E1..E32.
- SIGN at edge E33 writes hi/lo.
- mult_done is high for the cycle after E33.
- mult_busy is high from after E0 until E33.
- Result is readable by an instruction in EX in the cycle after E33: 33-cycle occupancy.
- Back-to-back: a new start_mult is accepted at E33+1 at the earliest.

## Configuration
- MULT_EARLY_OUT_EN defined:
  - CALC also exits to SIGN on the edge whose updated mplier equals 0.
  - Minimum of 1 CALC edge (srcb=0 or 1): E0 start, E1 CALC, E2 SIGN.
  - Results are identical; only latency shrinks.
- Not defined: fixed WIDTH CALC edges regardless of operand values.

## Structure
- Shared package mult_pkg holds:
  - state enum {IDLE, CALC, SIGN};
  - WIDTH and ITER (= WIDTH) constants;
  - CNT_W = $clog2(ITER).
- One natural sub-module: mult_abs, a parameterized-width conditional two's-complement negate (out = neg ? -in : in).
  - Instantiated twice at WIDTH for the operands.
  - Instantiated once at 2*WIDTH for the result.

## Test plan
- Unsigned 3 x 5: start at E0 -> hi=0x00000000, lo=0x0000000F at E33; mult_done one cycle; busy 33 cycles.
- Signed -2 x 3 (0xFFFFFFFE, 0x00000003, mult_sign=1) -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Signed, same operands -> hi=0, lo=1.
- Signed 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- hilo_read and a second start_mult at E5 -> mult_stall=1 through E33, hi/lo unchanged until E33. Second multiply accepted the cycle after.
- Reset low at E10 mid-CALC -> busy=0, hi=lo=0 immediately. A new 7 x 6 multiply after release gives lo=42.
  - With MULT_EARLY_OUT_EN, 0x1234 x 1 instead completes at E2 with lo=0x1234.
